// File: rtl/mem_llsc_ctrl.sv
// Memory-stage access controller: drives the data-cache handshake for loads,
// stores and ll.w/sc.w, formats load/store data, and owns the LLbit write port.
module mem_llsc_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        valid_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  rd_i,
   input  logic        llbit_i,
   output logic        stall_o,
   output logic        dreq_valid_o,
   input  logic        dreq_ready_i,
   output logic        dreq_wr_o,
   output logic [31:0] dreq_addr_o,
   output logic [3:0]  dreq_wstrb_o,
   output logic [31:0] dreq_wdata_o,
   input  logic        drsp_valid_i,
   input  logic [31:0] drsp_rdata_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        llbit_we_o,
   output logic        llbit_wdata_o,
   output logic        ale_o
);
   localparam logic [3:0] OP_LD_B  = 4'd1;
   localparam logic [3:0] OP_LD_BU = 4'd2;
   localparam logic [3:0] OP_LD_H  = 4'd3;
   localparam logic [3:0] OP_LD_HU = 4'd4;
   localparam logic [3:0] OP_LD_W  = 4'd5;
   localparam logic [3:0] OP_ST_B  = 4'd6;
   localparam logic [3:0] OP_ST_H  = 4'd7;
   localparam logic [3:0] OP_ST_W  = 4'd8;
   localparam logic [3:0] OP_LL_W  = 4'd9;
   localparam logic [3:0] OP_SC_W  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  req_op;
   logic [1:0]  req_off;
   logic [4:0]  req_rd;
   logic        misaligned;
   logic        op_known;
   logic        accept;
   logic        take_ale;
   logic        take_scfail;
   logic        take_req;
   logic        rsp_done;
   logic        fmt_wr;
   logic [3:0]  fmt_wstrb;
   logic [31:0] fmt_wdata;
   logic        wb_valid_next;
   logic [4:0]  wb_rd_next;
   logic [31:0] wb_data_next;
   logic        llbit_we_next;
   logic        llbit_wdata_next;
   logic        ale_next;

   function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LD_B:  fmt_load = {{24{b[7]}}, b};
         OP_LD_BU: fmt_load = {24'd0, b};
         OP_LD_H:  fmt_load = {{16{h[15]}}, h};
         OP_LD_HU: fmt_load = {16'd0, h};
         default:  fmt_load = word;
      endcase
   endfunction

   // Alignment rule per access size.
   always_comb begin
      misaligned = 1'b0;
      case (op_i)
         OP_LD_H, OP_LD_HU, OP_ST_H:          misaligned = addr_i[0];
         OP_LD_W, OP_ST_W, OP_LL_W, OP_SC_W: misaligned = (addr_i[1:0] != 2'b00);
         default:                             misaligned = 1'b0;
      endcase
   end

   assign op_known    = (op_i >= OP_LD_B) && (op_i <= OP_SC_W);
   assign accept      = (state == ST_IDLE) && valid_i && op_known && !flush_i;
   assign take_ale    = accept && misaligned;
   assign take_scfail = accept && !misaligned && (op_i == OP_SC_W) && !llbit_i;
   assign take_req    = accept && !misaligned && !take_scfail;
   assign rsp_done    = (state == ST_WAIT) && drsp_valid_i && !flush_i;

   // Store strobes and lane-replicated write data, formatted at acceptance.
   always_comb begin
      fmt_wr    = 1'b0;
      fmt_wstrb = 4'h0;
      fmt_wdata = 32'h0;
      case (op_i)
         OP_ST_B: begin
            fmt_wr    = 1'b1;
            fmt_wstrb = 4'b0001 << addr_i[1:0];
            fmt_wdata = {4{store_data_i[7:0]}};
         end
         OP_ST_H: begin
            fmt_wr    = 1'b1;
            fmt_wstrb = 4'b0011 << addr_i[1:0];
            fmt_wdata = {2{store_data_i[15:0]}};
         end
         OP_ST_W, OP_SC_W: begin
            fmt_wr    = 1'b1;
            fmt_wstrb = 4'hF;
            fmt_wdata = store_data_i;
         end
         default: begin
            fmt_wr    = 1'b0;
            fmt_wstrb = 4'h0;
            fmt_wdata = 32'h0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic; a flush that races the handshake must still drain the response.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (take_req) state_next = ST_REQ;
            else          state_next = ST_IDLE;
         end
         ST_REQ: begin
            if (dreq_ready_i) state_next = flush_i ? ST_DRAIN : ST_WAIT;
            else if (flush_i) state_next = ST_IDLE;
            else              state_next = ST_REQ;
         end
         ST_WAIT: begin
            if (drsp_valid_i) state_next = ST_IDLE;
            else if (flush_i) state_next = ST_DRAIN;
            else              state_next = ST_WAIT;
         end
         ST_DRAIN: begin
            if (drsp_valid_i) state_next = ST_IDLE;
            else              state_next = ST_DRAIN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Request latch: held stable for the whole REQ/WAIT window.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_op       <= 4'd0;
         req_off      <= 2'd0;
         req_rd       <= 5'd0;
         dreq_wr_o    <= 1'b0;
         dreq_addr_o  <= 32'h0;
         dreq_wstrb_o <= 4'h0;
         dreq_wdata_o <= 32'h0;
      end else if (take_req) begin
         req_op       <= op_i;
         req_off      <= addr_i[1:0];
         req_rd       <= rd_i;
         dreq_wr_o    <= fmt_wr;
         dreq_addr_o  <= {addr_i[31:2], 2'b00};
         dreq_wstrb_o <= fmt_wstrb;
         dreq_wdata_o <= fmt_wdata;
      end
   end

   assign dreq_valid_o = (state == ST_REQ);
   assign stall_o      = (state == ST_REQ) || (state == ST_DRAIN) ||
                         ((state == ST_WAIT) && !drsp_valid_i) || take_req;

   // Output decode: next-cycle pulses and writeback payload.
   always_comb begin
      wb_valid_next    = 1'b0;
      wb_rd_next       = wb_rd_o;
      wb_data_next     = wb_data_o;
      llbit_we_next    = 1'b0;
      llbit_wdata_next = llbit_wdata_o;
      ale_next         = 1'b0;
      if (take_ale) begin
         ale_next = 1'b1;
      end else if (take_scfail) begin
         wb_valid_next    = 1'b1;
         wb_rd_next       = rd_i;
         wb_data_next     = 32'h0;
         llbit_we_next    = 1'b1;
         llbit_wdata_next = 1'b0;
      end else if (rsp_done) begin
         case (req_op)
            OP_LD_B, OP_LD_BU, OP_LD_H, OP_LD_HU, OP_LD_W: begin
               wb_valid_next = 1'b1;
               wb_rd_next    = req_rd;
               wb_data_next  = fmt_load(req_op, req_off, drsp_rdata_i);
            end
            OP_LL_W: begin
               wb_valid_next    = 1'b1;
               wb_rd_next       = req_rd;
               wb_data_next     = drsp_rdata_i;
               llbit_we_next    = 1'b1;
               llbit_wdata_next = 1'b1;
            end
            OP_SC_W: begin
               wb_valid_next    = 1'b1;
               wb_rd_next       = req_rd;
               wb_data_next     = 32'h1;
               llbit_we_next    = 1'b1;
               llbit_wdata_next = 1'b0;
            end
            default: wb_valid_next = 1'b0;
         endcase
      end else begin
         ale_next = 1'b0;
      end
   end

   // Registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_o    <= 1'b0;
         wb_rd_o       <= 5'd0;
         wb_data_o     <= 32'h0;
         llbit_we_o    <= 1'b0;
         llbit_wdata_o <= 1'b0;
         ale_o         <= 1'b0;
      end else begin
         wb_valid_o    <= wb_valid_next;
         wb_rd_o       <= wb_rd_next;
         wb_data_o     <= wb_data_next;
         llbit_we_o    <= llbit_we_next;
         llbit_wdata_o <= llbit_wdata_next;
         ale_o         <= ale_next;
      end
   end
endmodule

// File: tb/tb_mem_llsc_ctrl.sv
// Directed bench for mem_llsc_ctrl: a transaction-level model predicts every
// cycle's outputs, and a negedge compare process checks them against the DUT.
module tb_mem_llsc_ctrl;
   localparam logic [3:0] LD_B = 4'd1, LD_BU = 4'd2, LD_H = 4'd3, LD_HU = 4'd4, LD_W = 4'd5;
   localparam logic [3:0] ST_B = 4'd6, ST_H = 4'd7, ST_W = 4'd8, LL_W = 4'd9, SC_W = 4'd10;

   logic        clk = 1'b0;
   logic        rst, flush_i, valid_i, llbit_i;
   logic [3:0]  op_i;
   logic [31:0] addr_i, store_data_i;
   logic [4:0]  rd_i;
   logic        stall_o, dreq_valid_o, dreq_ready_i, dreq_wr_o;
   logic [31:0] dreq_addr_o, dreq_wdata_o;
   logic [3:0]  dreq_wstrb_o;
   logic        drsp_valid_i;
   logic [31:0] drsp_rdata_i;
   logic        wb_valid_o, llbit_we_o, llbit_wdata_o, ale_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;

   mem_llsc_ctrl dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .op_i(op_i),
      .addr_i(addr_i), .store_data_i(store_data_i), .rd_i(rd_i), .llbit_i(llbit_i),
      .stall_o(stall_o), .dreq_valid_o(dreq_valid_o), .dreq_ready_i(dreq_ready_i),
      .dreq_wr_o(dreq_wr_o), .dreq_addr_o(dreq_addr_o), .dreq_wstrb_o(dreq_wstrb_o),
      .dreq_wdata_o(dreq_wdata_o), .drsp_valid_i(drsp_valid_i), .drsp_rdata_i(drsp_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .llbit_we_o(llbit_we_o), .llbit_wdata_o(llbit_wdata_o), .ale_o(ale_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // expectation for the current cycle (e_*) and pulses due next cycle (p_*)
   logic        e_stall, e_dvalid, e_wr, e_wb_valid, e_we, e_wdata, e_ale;
   logic [31:0] e_addr, e_dwdata, e_wb_data;
   logic [3:0]  e_wstrb;
   logic [4:0]  e_wb_rd;
   logic        p_wb_valid, p_we, p_wdata, p_ale;
   logic [4:0]  p_wb_rd;
   logic [31:0] p_wb_data;
   logic        m_llbit;
   logic [3:0]  cap_wstrb;
   logic [31:0] cap_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_misaligned(input logic [3:0] op, input logic [31:0] addr);
      bit half, word;
      half = (op == LD_H) || (op == LD_HU) || (op == ST_H);
      word = (op == LD_W) || (op == ST_W) || (op == LL_W) || (op == SC_W);
      return (half && (addr % 2 != 0)) || (word && (addr % 4 != 0));
   endfunction

   function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * addr[1:0])) & 32'hFF;
      h = (w >> (16 * addr[1])) & 32'hFFFF;
      case (op)
         LD_B:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         LD_BU:   return b;
         LD_H:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         LD_HU:   return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] ref_strb(input logic [3:0] op, input logic [31:0] addr);
      case (op)
         ST_B:       return 4'(1 << (addr % 4));
         ST_H:       return 4'(3 << (addr % 4));
         ST_W, SC_W: return 4'hF;
         default:    return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
      case (op)
         ST_B:    return (d & 32'hFF) * 32'h0101_0101;
         ST_H:    return (d & 32'hFFFF) * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   // Advance one cycle: LLbit takes the previous cycle's write, pending pulses become due.
   task automatic tick();
      @(posedge clk);
      #1;
      if (e_we) m_llbit = e_wdata;
      e_wb_valid = p_wb_valid; e_wb_rd = p_wb_rd; e_wb_data = p_wb_data;
      e_we = p_we; e_wdata = p_wdata; e_ale = p_ale;
      p_wb_valid = 1'b0; p_we = 1'b0; p_ale = 1'b0;
      e_stall = 1'b0; e_dvalid = 1'b0;
      valid_i = 1'b0; flush_i = 1'b0; dreq_ready_i = 1'b0; drsp_valid_i = 1'b0;
      llbit_i = m_llbit;
   endtask

   task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input int rdy_wait, input int rsp_wait, input bit flush_wait);
      tick();
      valid_i = 1'b1; op_i = op; addr_i = addr; store_data_i = data; rd_i = rd;
      if (is_misaligned(op, addr)) begin
         p_ale = 1'b1;
      end else if (op == SC_W && !m_llbit) begin
         p_wb_valid = 1'b1; p_wb_rd = rd; p_wb_data = 32'h0; p_we = 1'b1; p_wdata = 1'b0;
      end else begin
         e_stall = 1'b1;
         e_addr = addr & 32'hFFFF_FFFC;
         e_wr = (op == ST_B) || (op == ST_H) || (op == ST_W) || (op == SC_W);
         e_wstrb = ref_strb(op, addr);
         e_dwdata = ref_wdata(op, data);
         for (int i = 0; i <= rdy_wait; i++) begin
            tick();
            valid_i = 1'b1; e_stall = 1'b1; e_dvalid = 1'b1;
            dreq_ready_i = (i == rdy_wait);
         end
         if (flush_wait) begin
            tick(); flush_i = 1'b1; e_stall = 1'b1;
         end
         for (int i = 0; i < rsp_wait; i++) begin
            tick(); valid_i = !flush_wait; e_stall = 1'b1;
         end
         tick();
         valid_i = !flush_wait; drsp_valid_i = 1'b1; drsp_rdata_i = rdata;
         e_stall = flush_wait;
         if (!flush_wait && !e_wr || !flush_wait && op == SC_W) begin
            p_wb_valid = 1'b1; p_wb_rd = rd;
            p_wb_data = (op == SC_W) ? 32'h1 : ref_load(op, addr, rdata);
            p_we = (op == LL_W) || (op == SC_W);
            p_wdata = (op == LL_W);
         end
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", 32'(stall_o), 32'(e_stall));
         check("dreq_valid", 32'(dreq_valid_o), 32'(e_dvalid));
         if (e_dvalid) begin
            check("dreq_addr", dreq_addr_o, e_addr);
            check("dreq_wr", 32'(dreq_wr_o), 32'(e_wr));
            check("dreq_wstrb", 32'(dreq_wstrb_o), 32'(e_wstrb));
            if (e_wr) check("dreq_wdata", dreq_wdata_o, e_dwdata);
         end
         check("wb_valid", 32'(wb_valid_o), 32'(e_wb_valid));
         if (e_wb_valid) begin
            check("wb_rd", 32'(wb_rd_o), 32'(e_wb_rd));
            check("wb_data", wb_data_o, e_wb_data);
         end
         check("llbit_we", 32'(llbit_we_o), 32'(e_we));
         if (e_we) check("llbit_wdata", 32'(llbit_wdata_o), 32'(e_wdata));
         check("ale", 32'(ale_o), 32'(e_ale));
         if (dreq_valid_o && dreq_ready_i) begin
            cap_wstrb = dreq_wstrb_o;
            cap_wdata = dreq_wdata_o;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; op_i = 4'd0; addr_i = 32'h0;
      store_data_i = 32'h0; rd_i = 5'd0; llbit_i = 1'b0; dreq_ready_i = 1'b0;
      drsp_valid_i = 1'b0; drsp_rdata_i = 32'h0; m_llbit = 1'b0;
      e_stall = 1'b0; e_dvalid = 1'b0; e_wr = 1'b0; e_wb_valid = 1'b0; e_we = 1'b0;
      e_wdata = 1'b0; e_ale = 1'b0; e_addr = 32'h0; e_dwdata = 32'h0; e_wb_data = 32'h0;
      e_wstrb = 4'h0; e_wb_rd = 5'd0; p_wb_valid = 1'b0; p_we = 1'b0; p_wdata = 1'b0;
      p_ale = 1'b0; p_wb_rd = 5'd0; p_wb_data = 32'h0; cap_wstrb = 4'h0; cap_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_ctrl", 32'({stall_o, dreq_valid_o, dreq_wr_o, dreq_wstrb_o, wb_valid_o,
                            wb_rd_o, llbit_we_o, llbit_wdata_o, ale_o}), 32'h0);
      check("rst_dreq_addr", dreq_addr_o, 32'h0);
      check("rst_dreq_wdata", dreq_wdata_o, 32'h0);
      check("rst_wb_data", wb_data_o, 32'h0);

      do_mem(LD_B, 32'h0000_1003, 32'h0, 5'd5, 32'h80FF_FF7F, 0, 0, 1'b0);
      tick();
      @(negedge clk);
      check("pin_ldb_data", wb_data_o, 32'hFFFF_FF80);

      do_mem(LL_W, 32'h0000_2000, 32'h0, 5'd6, 32'h1234_5678, 0, 1, 1'b0);
      tick();
      @(negedge clk);
      check("pin_ll_data", wb_data_o, 32'h1234_5678);
      check("pin_ll_we", 32'({llbit_we_o, llbit_wdata_o}), 32'h3);

      do_mem(SC_W, 32'h0000_2000, 32'hA5A5_A5A5, 5'd8, 32'h0, 1, 0, 1'b0);
      check("pin_sc_wstrb", 32'(cap_wstrb), 32'hF);
      tick();
      @(negedge clk);
      check("pin_sc_data", wb_data_o, 32'h1);

      do_mem(SC_W, 32'h0000_2000, 32'h1111_1111, 5'd9, 32'h0, 0, 0, 1'b0);
      tick();
      @(negedge clk);
      check("pin_scfail", 32'({wb_valid_o, llbit_we_o, llbit_wdata_o}), 32'h6);

      do_mem(ST_H, 32'h0000_3002, 32'h0000_BEEF, 5'd0, 32'h0, 3, 1, 1'b0);
      check("pin_sth_wstrb", 32'(cap_wstrb), 32'hC);
      check("pin_sth_wdata", cap_wdata, 32'hBEEF_BEEF);

      do_mem(LD_W, 32'h0000_4001, 32'h0, 5'd3, 32'h0, 0, 0, 1'b0);
      tick();
      @(negedge clk);
      check("pin_ale", 32'(ale_o), 32'h1);

      do_mem(LD_HU, 32'h0000_4002, 32'h0, 5'd10, 32'h8001_0000, 0, 0, 1'b0);
      do_mem(LD_H,  32'h0000_4002, 32'h0, 5'd11, 32'h8001_0000, 1, 2, 1'b0);
      do_mem(LD_BU, 32'h0000_4001, 32'h0, 5'd12, 32'h0000_9900, 0, 0, 1'b0);
      do_mem(ST_B,  32'h0000_5001, 32'h0000_0012, 5'd0, 32'h0, 0, 0, 1'b0);
      check("pin_stb_wdata", cap_wdata, 32'h1212_1212);
      do_mem(LD_H,  32'h0000_4003, 32'h0, 5'd13, 32'h0, 0, 0, 1'b0);
      do_mem(ST_W,  32'h0000_6004, 32'hCAFE_F00D, 5'd0, 32'h0, 2, 0, 1'b0);

      // flush while waiting for the response, which then arrives 2 cycles later
      do_mem(LD_W, 32'h0000_6000, 32'h0, 5'd14, 32'h7777_7777, 0, 2, 1'b1);
      repeat (2) tick();

      // reset asserted in WAIT; a late response must be ignored
      tick();
      valid_i = 1'b1; op_i = LD_W; addr_i = 32'h0000_5000; rd_i = 5'd7; e_stall = 1'b1;
      tick();
      valid_i = 1'b1; dreq_ready_i = 1'b1; e_stall = 1'b1; e_dvalid = 1'b1;
      e_addr = 32'h0000_5000; e_wr = 1'b0; e_wstrb = 4'h0;
      tick();
      rst = 1'b1; e_stall = 1'b1;
      tick();
      rst = 1'b0; m_llbit = 1'b0; llbit_i = 1'b0;
      drsp_valid_i = 1'b1; drsp_rdata_i = 32'h5555_5555;
      @(negedge clk);
      check("rst_mid_addr", dreq_addr_o, 32'h0);
      check("rst_mid_wb", 32'({wb_valid_o, wb_rd_o}), 32'h0);
      check("rst_mid_wb_data", wb_data_o, 32'h0);
      repeat (2) tick();

      // flush in IDLE suppresses acceptance
      tick();
      valid_i = 1'b1; op_i = LD_W; addr_i = 32'h0000_7000; rd_i = 5'd4; flush_i = 1'b1;
      repeat (3) tick();
      do_mem(LD_W, 32'h0000_7000, 32'h0, 5'd4, 32'h0BAD_F00D, 0, 0, 1'b0);
      repeat (2) tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
